mem_model_apb_arb: RTL

MEM_MODEL_APB_ARB -- requirements
Module: mem_model_apb_arb

---
 rtl/mem_model_apb_arb.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_model_apb_arb.sv
// mem_model_apb_arb: two-requester round-robin APB arbiter; optional access timeout under MEM_MODEL_APB_ARB_TIMEOUT_EN.
module mem_model_apb_arb #(
  parameter int ADDRWIDTH      = 32,
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s0_psel,
  input  logic                   s0_penable,
  input  logic [ADDRWIDTH-1:0]   s0_paddr,
  input  logic                   s0_pwrite,
  input  logic [DATAWIDTH-1:0]   s0_pwdata,
  input  logic [DATAWIDTH/8-1:0] s0_pstrb,
  input  logic [2:0]             s0_pprot,
  output logic [DATAWIDTH-1:0]   s0_prdata,
  output logic                   s0_pready,
  output logic                   s0_pslverr,
  input  logic                   s1_psel,
  input  logic                   s1_penable,
  input  logic [ADDRWIDTH-1:0]   s1_paddr,
  input  logic                   s1_pwrite,
  input  logic [DATAWIDTH-1:0]   s1_pwdata,
  input  logic [DATAWIDTH/8-1:0] s1_pstrb,
  input  logic [2:0]             s1_pprot,
  output logic [DATAWIDTH-1:0]   s1_prdata,
  output logic                   s1_pready,
  output logic                   s1_pslverr,
  output logic                   m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [ADDRWIDTH-1:0]   m_paddr,
  output logic [DATAWIDTH-1:0]   m_pwdata,
  output logic [DATAWIDTH/8-1:0] m_pstrb,
  output logic [2:0]             m_pprot,
  input  logic [DATAWIDTH-1:0]   m_prdata,
  input  logic                   m_pready,
  input  logic                   m_pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_next;
  logic grant, win, req_any, finish, expired, err;
  logic [DATAWIDTH-1:0] data;
  logic unused;
  assign unused = ^{s0_penable, s1_penable, TIMEOUT_CYCLES[0]};
  assign req_any = s0_psel | s1_psel;
  // grant doubles as the round-robin pointer: on a tie the other requester wins
  assign win = (s0_psel & s1_psel) ? ~grant : s1_psel;
`ifdef MEM_MODEL_APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) cnt <= (rst || state != ACCESS) ? '0 : cnt + 1'b1;
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif
  assign finish = state == ACCESS && (m_pready || expired);
  assign err = m_pready ? m_pslverr : 1'b1;
  assign data = m_pready ? m_prdata : '0;
  assign m_psel = state == SETUP || state == ACCESS;
  assign m_penable = state == ACCESS;
  always_comb begin
    state_next = state == IDLE   ? (req_any ? SETUP : IDLE) :
                 state == SETUP  ? ACCESS :
                 state == ACCESS ? (finish ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b1;
      m_pwrite   <= 1'b0;
      m_paddr    <= '0;
      m_pwdata   <= '0;
      m_pstrb    <= '0;
      m_pprot    <= '0;
      s0_prdata  <= '0;
      s1_prdata  <= '0;
      s0_pready  <= 1'b0;
      s1_pready  <= 1'b0;
      s0_pslverr <= 1'b0;
      s1_pslverr <= 1'b0;
    end else begin
      if (state == IDLE && req_any) begin
        grant    <= win;
        m_pwrite <= win ? s1_pwrite : s0_pwrite;
        m_paddr  <= win ? s1_paddr  : s0_paddr;
        m_pwdata <= win ? s1_pwdata : s0_pwdata;
        m_pstrb  <= win ? s1_pstrb  : s0_pstrb;
        m_pprot  <= win ? s1_pprot  : s0_pprot;
      end
      s0_pready  <= finish && !grant;
      s1_pready  <= finish && grant;
      s0_pslverr <= finish && !grant && err;
      s1_pslverr <= finish && grant && err;
      if (finish && !grant) s0_prdata <= data;
      if (finish && grant) s1_prdata <= data;
    end
  end
endmodule
